// File: rtl/fft8_bfly_sequencer_pkg.sv
// Shared constants, state encoding and butterfly address helper for the 8-point
// radix-2 DIT FFT butterfly sequencer.
package fft8_pkg;

    localparam int unsigned N_POINTS       = 8;
    localparam int unsigned LOG2N          = 3;
    localparam int unsigned N_STAGES       = 3;
    localparam int unsigned BFLY_PER_STAGE = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;

    typedef struct packed {
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [LOG2N-2:0] tw;
    } bfly_addr_t;

    // Butterfly k of stage s: span = 1<<s pairs A with B = A + span.
    function automatic bfly_addr_t bfly_addr(input logic [1:0] stage, input logic [1:0] k);
        bfly_addr_t       r;
        logic [LOG2N-1:0] span;
        logic [LOG2N-1:0] grp;
        logic [LOG2N-1:0] pos;
        span = 3'd1 << stage;
        grp  = {1'b0, k} >> stage;
        pos  = {1'b0, k} & (span - 3'd1);
        r.a  = (grp << (stage + 2'd1)) | pos;
        r.b  = r.a + span;
        r.tw = 2'(pos << (2'd2 - stage));
        return r;
    endfunction

endpackage

// File: rtl/fft8_bfly_sequencer_if.sv
// Control/address bundle between the FFT butterfly sequencer and its datapath.
// FFT_SEQ_HOLD_EN adds the issue-stall input hold.
interface fft8_bfly_sequencer_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned TW_W   = 2
);
    logic              start;
`ifdef FFT_SEQ_HOLD_EN
    logic              hold;
`endif
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [TW_W-1:0]   tw_idx;
    logic              op_sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        stage;
    logic              busy;
    logic              done;

    modport master (
        input  start,
`ifdef FFT_SEQ_HOLD_EN
        input  hold,
`endif
        output rd_en, rd_addr_a, rd_addr_b, tw_idx, op_sel,
        output wr_en, wr_addr, stage, busy, done
    );

    modport slave (
        output start,
`ifdef FFT_SEQ_HOLD_EN
        output hold,
`endif
        input  rd_en, rd_addr_a, rd_addr_b, tw_idx, op_sel,
        input  wr_en, wr_addr, stage, busy, done
    );

endinterface

// File: rtl/fft8_bfly_sequencer_wr_delay_line.sv
// Free-running {we, addr} shift register that aligns write-back with the
// butterfly datapath latency; clearing it drops every in-flight write.
module fft8_wr_delay_line #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [DEPTH-1:0]             we_q, we_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        we_d      = '0;
        addr_d    = '0;
        we_d[0]   = we_i;
        addr_d[0] = addr_i;
        for (int i = 1; i < DEPTH; i++) begin
            we_d[i]   = we_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= '0;
            addr_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end

    assign we_o   = we_q[DEPTH-1];
    assign addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/fft8_bfly_sequencer.sv
// Issue/drain sequencer for the shared butterfly of an 8-point radix-2 DIT FFT.
// Define FFT_SEQ_HOLD_EN to add the hold input that stalls issue.
module fft8_bfly_sequencer #(
    parameter int unsigned BF_LATENCY = 2,  // legal 1..7
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned TW_W       = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    fft8_bfly_sequencer_if.master  bus
);
    import fft8_pkg::*;

    localparam int unsigned CNT_W = $clog2(N_POINTS);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        stage_q, stage_d;
    logic [2:0]        drain_q, drain_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [TW_W-1:0]   tw_q, tw_d;
    logic              hold;
    logic              issue;
    bfly_addr_t        cur;
    logic [ADDR_W-1:0] cur_a, cur_b;

`ifdef FFT_SEQ_HOLD_EN
    assign hold = bus.hold;
`else
    assign hold = 1'b0;
`endif

    // Counter pairs: bit 0 selects add/sub, upper bits pick the butterfly.
    assign cur   = bfly_addr(stage_q, cnt_q[CNT_W-1:1]);
    assign cur_a = ADDR_W'(cur.a);
    assign cur_b = ADDR_W'(cur.b);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        drain_d = drain_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    issue = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(2 * BFLY_PER_STAGE - 1)) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == 3'(BF_LATENCY - 1)) begin
                    if (stage_q == 2'(N_STAGES - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        stage_d = stage_q + 2'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address outputs keep the last issued butterfly while not issuing.
    always_comb begin
        addr_a_d = issue ? cur_a : addr_a_q;
        addr_b_d = issue ? cur_b : addr_b_q;
        tw_d     = issue ? TW_W'(cur.tw) : tw_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stage_q  <= '0;
            drain_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            drain_q  <= drain_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    fft8_wr_delay_line #(
        .DEPTH  (BF_LATENCY),
        .ADDR_W (ADDR_W)
    ) u_wr_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (issue),
        .addr_i (cnt_q[0] ? cur_b : cur_a),
        .we_o   (bus.wr_en),
        .addr_o (bus.wr_addr)
    );

    assign bus.rd_en     = issue;
    assign bus.rd_addr_a = addr_a_d;
    assign bus.rd_addr_b = addr_b_d;
    assign bus.tw_idx    = tw_d;
    assign bus.op_sel    = (issue && cnt_q[0]) ? OP_SUB : OP_ADD;
    assign bus.stage     = stage_q;
    assign bus.busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_fft8_bfly_sequencer.sv
// Randomized bench for fft8_bfly_sequencer at BF_LATENCY 1, 2 and 5 against a
// per-cycle timeline model built from the issue/drain schedule.
module tb_fft8_bfly_sequencer;

    localparam int NDUT = 3;
    localparam int MAXP = 2048;
    localparam int RLO  = 320;
    localparam int RHI  = 1150;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 5;
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic hold = 1'b0;
    int   per = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   pin_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) per <= per + 1;

    logic       mon_rd[NDUT], mon_op[NDUT], mon_we[NDUT], mon_busy[NDUT], mon_done[NDUT];
    logic [2:0] mon_a[NDUT], mon_b[NDUT], mon_wa[NDUT];
    logic [1:0] mon_tw[NDUT], mon_stage[NDUT];

    genvar g;
    for (g = 0; g < NDUT; g++) begin : g_dut
        fft8_bfly_sequencer_if #(.ADDR_W(3), .TW_W(2)) bus ();
        assign bus.start = start;
`ifdef FFT_SEQ_HOLD_EN
        assign bus.hold = hold;
`endif
        fft8_bfly_sequencer #(
            .BF_LATENCY (lat_of(g)),
            .ADDR_W     (3),
            .TW_W       (2)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign mon_rd[g]    = bus.rd_en;
        assign mon_op[g]    = bus.op_sel;
        assign mon_we[g]    = bus.wr_en;
        assign mon_busy[g]  = bus.busy;
        assign mon_done[g]  = bus.done;
        assign mon_a[g]     = bus.rd_addr_a;
        assign mon_b[g]     = bus.rd_addr_b;
        assign mon_wa[g]    = bus.wr_addr;
        assign mon_tw[g]    = bus.tw_idx;
        assign mon_stage[g] = bus.stage;
    end

    // Expected behaviour indexed by period (period p follows the p-th rising edge).
    bit       e_rd[NDUT][MAXP], e_op[NDUT][MAXP], e_we[NDUT][MAXP];
    bit       e_busy[NDUT][MAXP], e_done[NDUT][MAXP];
    bit [2:0] e_a[NDUT][MAXP], e_b[NDUT][MAXP], e_wa[NDUT][MAXP];
    bit [1:0] e_tw[NDUT][MAXP], e_stage[NDUT][MAXP];
    bit       hold_at[MAXP];
    int       done_p[NDUT];
    int       rd_cnt[NDUT];
    int       lit_base;
    int       lit_mode;

    task automatic check(input string nm, input int i, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d (L=%0d) period %0d: got %0d, expected %0d",
                     nm, i, lat_of(i), per, act, exp);
        end
    endtask

    // START seen in period p: run is accepted at the following edge.
    task automatic plan(input int i, input int p);
        int t, L, k, span, grp, pos, a;
        L = lat_of(i);
        t = p + 1;
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 8; c++) begin
                while (t < MAXP && hold_at[t]) begin
                    e_busy[i][t] = 1'b1;
                    e_stage[i][t] = 2'(s);
                    t++;
                end
                if (t + L < MAXP) begin
                    k    = c / 2;
                    span = 1 << s;
                    grp  = k / span;
                    pos  = k % span;
                    a    = grp * 2 * span + pos;
                    e_rd[i][t]    = 1'b1;
                    e_op[i][t]    = 1'(c % 2);
                    e_a[i][t]     = 3'(a);
                    e_b[i][t]     = 3'(a + span);
                    e_tw[i][t]    = 2'(pos << (2 - s));
                    e_busy[i][t]  = 1'b1;
                    e_stage[i][t] = 2'(s);
                    e_we[i][t+L]  = 1'b1;
                    e_wa[i][t+L]  = (c % 2 == 1) ? 3'(a + span) : 3'(a);
                end
                t++;
            end
            for (int d = 0; d < L; d++) begin
                if (t < MAXP) begin
                    e_busy[i][t]  = 1'b1;
                    e_stage[i][t] = 2'(s);
                end
                t++;
            end
        end
        if (t < MAXP) e_done[i][t] = 1'b1;
        done_p[i] = t;
    endtask

    task automatic abort_all(input int p);
        for (int i = 0; i < NDUT; i++) begin
            for (int q = p; q < MAXP; q++) begin
                e_rd[i][q] = 0; e_op[i][q] = 0; e_we[i][q] = 0;
                e_busy[i][q] = 0; e_done[i][q] = 0;
            end
            done_p[i] = -1;
            rd_cnt[i] = 0;
        end
        lit_mode = 0;
    endtask

    task automatic lit_chk(input int a, input int b, input int tw, input int op);
        check("lit_rd_en", 1, int'(mon_rd[1]), 1);
        check("lit_addr_a", 1, int'(mon_a[1]), a);
        check("lit_addr_b", 1, int'(mon_b[1]), b);
        check("lit_tw_idx", 1, int'(mon_tw[1]), tw);
        check("lit_op_sel", 1, int'(mon_op[1]), op);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            done_p[i] = -1;
            rd_cnt[i] = 0;
        end
        lit_mode = 0;
        lit_base = 0;
    end

    always @(negedge clk) begin
        if (per < MAXP - 64) begin
            if (!rst_n) begin
                abort_all(per);
                for (int i = 0; i < NDUT; i++) begin
                    check("rst_rd_en", i, int'(mon_rd[i]), 0);
                    check("rst_wr_en", i, int'(mon_we[i]), 0);
                    check("rst_op_sel", i, int'(mon_op[i]), 0);
                    check("rst_busy", i, int'(mon_busy[i]), 0);
                    check("rst_done", i, int'(mon_done[i]), 0);
                    check("rst_stage", i, int'(mon_stage[i]), 0);
                    check("rst_addr_a", i, int'(mon_a[i]), 0);
                    check("rst_addr_b", i, int'(mon_b[i]), 0);
                    check("rst_tw_idx", i, int'(mon_tw[i]), 0);
                    check("rst_wr_addr", i, int'(mon_wa[i]), 0);
                end
            end else begin
                for (int i = 0; i < NDUT; i++) begin
                    check("rd_en", i, int'(mon_rd[i]), int'(e_rd[i][per]));
                    check("op_sel", i, int'(mon_op[i]), int'(e_op[i][per]));
                    check("wr_en", i, int'(mon_we[i]), int'(e_we[i][per]));
                    check("busy", i, int'(mon_busy[i]), int'(e_busy[i][per]));
                    check("done", i, int'(mon_done[i]), int'(e_done[i][per]));
                    if (e_rd[i][per]) begin
                        check("rd_addr_a", i, int'(mon_a[i]), int'(e_a[i][per]));
                        check("rd_addr_b", i, int'(mon_b[i]), int'(e_b[i][per]));
                        check("tw_idx", i, int'(mon_tw[i]), int'(e_tw[i][per]));
                    end
                    if (e_we[i][per]) check("wr_addr", i, int'(mon_wa[i]), int'(e_wa[i][per]));
                    if (e_busy[i][per]) check("stage", i, int'(mon_stage[i]), int'(e_stage[i][per]));
                    if (mon_rd[i]) rd_cnt[i]++;
                    if (per == done_p[i]) begin
                        check("issues_per_run", i, rd_cnt[i], 24);
                        rd_cnt[i] = 0;
                    end
                    if (i == 1 && lit_mode != 0) begin
                        case (per - lit_base)
                            1:  lit_chk(0, 1, 0, 0);
                            2:  lit_chk(0, 1, 0, 1);
                            13: if (lit_mode == 1) lit_chk(1, 3, 2, 0);
                            14: if (lit_mode == 1) lit_chk(1, 3, 2, 1);
                            27: if (lit_mode == 1) lit_chk(3, 7, 3, 0);
                            28: if (lit_mode == 1) lit_chk(3, 7, 3, 1);
                            default: ;
                        endcase
                        if (per - lit_base == ((lit_mode == 2) ? 34 : 31)) begin
                            check("lit_done", 1, int'(mon_done[1]), 1);
                            check("lit_busy_at_done", 1, int'(mon_busy[1]), 0);
                            lit_mode = 0;
                        end
                    end
                    if (start && per > done_p[i]) begin
                        plan(i, per);
                        if (i == 1 && pin_mode != 0) begin
                            lit_mode = pin_mode;
                            lit_base = per;
                            check("model_done_cycle", 1, done_p[1] - per,
                                  (pin_mode == 2) ? 34 : 31);
                            if (pin_mode == 1) begin
                                check("model_a_s1k1", 1, int'(e_a[1][per+13]), 1);
                                check("model_b_s1k1", 1, int'(e_b[1][per+13]), 3);
                                check("model_tw_s1k1", 1, int'(e_tw[1][per+13]), 2);
                                check("model_wr_b_s1k1", 1, int'(e_wa[1][per+16]), 3);
                            end
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        hold = (per < MAXP) ? hold_at[per] : 1'b0;
    end

    task automatic goto(input int q);
        while (per < q) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    int p0, p1, p2, p3, r;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int p = 0; p < MAXP; p++) hold_at[p] = 1'b0;
`ifdef FFT_SEQ_HOLD_EN
        for (int p = RLO; p < RHI; p++) hold_at[p] = ($urandom_range(0, 6) == 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        goto(8);

        // Full run with ignored STARTs while busy and in the L=2 DONE cycle.
        p0 = per;
        pin_mode = 1;
        pulse_start();
        pin_mode = 0;
        goto(p0 + 5);
        pulse_start();
        goto(p0 + 20);
        pulse_start();
        goto(p0 + 31);
        pulse_start();
        goto(p0 + 100);

        p1 = per;
        pulse_start();
        goto(p1 + 50);

        // Reset in the middle of stage 1.
        p2 = per;
        pulse_start();
        goto(p2 + 12);
        rst_n = 1'b0;
        goto(p2 + 14);
        rst_n = 1'b1;
        goto(p2 + 60);

`ifdef FFT_SEQ_HOLD_EN
        p3 = per;
        hold_at[p3 + 15] = 1'b1;
        hold_at[p3 + 16] = 1'b1;
        hold_at[p3 + 17] = 1'b1;
        pin_mode = 2;
        pulse_start();
        pin_mode = 0;
        goto(p3 + 60);
`else
        p3 = per;
        goto(p3 + 2);
`endif

        goto(RLO);
        while (per < RHI) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                pulse_start();
            end else if (r < 9) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
                rst_n = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        goto(RHI + 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
